uart_rx_frame_counter: RTL and testbench
========================================

UART_RX_FRAME_COUNTER -- requirements
Module: uart_rx_frame_counter

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of prescale and edge_count.
REQ-002 SHALL have parameter BIT_CNT_W, default 4, width of bit_count; it must hold values up to 11.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port counter_en, input, 1, count enable from the RX FSM.
REQ-006 SHALL have port restart, input, 1, synchronous abort/clear request.
REQ-007 SHALL have port prescale, input, PRESCALE_W, oversampling ratio P (clk edges per bit).
REQ-008 SHALL have port data_len, input, 2, data bits: 00=5, 01=6, 10=7, 11=8.
REQ-009 SHALL have port par_en, input, 1, parity bit present.
REQ-010 SHALL have port stop2, input, 1, two stop bits when 1, else one.
REQ-011 SHALL have port edge_count, output, PRESCALE_W, edge index within the current bit.
REQ-012 SHALL have port bit_count, output, BIT_CNT_W, bit index in the frame (0 = start bit).
REQ-013 SHALL have port sample_strobe, output, 1, asserted on the three mid-bit sample edges.
REQ-014 SHALL have port sample_last, output, 1, asserted on the third (final) sample edge.
REQ-015 SHALL have port bit_done, output, 1, one-cycle pulse after each bit boundary.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse after the frame's last bit.
REQ-017 SHALL have port busy, output, 1, high while in ACTIVE.
REQ-018 SHALL have port cfg_err, output, 1, latched prescale is invalid (P < 4).

Function
REQ-019 SHALL implement states IDLE and ACTIVE; busy = (state == ACTIVE).
REQ-020 SHALL compute frame length L = 1 + (data_len + 5) + par_en + 1 + stop2, giving a range of 7 to 12.
REQ-021 SHALL, in IDLE with counter_en=1 and restart=0, latch prescale, data_len, par_en and stop2, then enter ACTIVE with edge_count<=1 and bit_count<=0.
REQ-022 SHALL ignore changes to prescale, data_len, par_en and stop2 while in ACTIVE; the latched values govern the rest of the frame.
REQ-023 SHALL, in ACTIVE with counter_en=1 and edge_count != P-1, increment edge_count by 1.
REQ-024 SHALL, in ACTIVE with counter_en=1, edge_count == P-1 and bit_count != L-1, clear edge_count, increment bit_count, and pulse bit_done on the next cycle.
REQ-025 SHALL, in ACTIVE with counter_en=1, edge_count == P-1 and bit_count == L-1, clear both counters, return to IDLE, and pulse both bit_done and frame_done on the next cycle.
REQ-026 SHALL hold both counters and the state when counter_en=0; bit_done and frame_done are 0 in that case.
REQ-027 SHALL decode sample_strobe combinationally from registered state: ACTIVE and edge_count in {h-1, h, h+1}, where h = P>>1.
REQ-028 SHALL decode sample_last combinationally from registered state: ACTIVE and edge_count == h+1.
REQ-029 SHALL compute all comparisons at PRESCALE_W+1 bits so that P-1 never wraps.
REQ-030 SHALL, when the latched P < 4, set cfg_err=1, stay in IDLE, hold the counters at 0 and emit no pulses; cfg_err clears on the next valid latch or on reset/restart.
REQ-031 SHALL, on restart=1 (taking priority over counter_en), clear the counters, enter IDLE and suppress bit_done and frame_done on the following cycle.
REQ-032 SHALL allow counter_en to stay high across the frame_done cycle; the next frame latches its configuration on the first enabled cycle spent in IDLE.

Reset
REQ-033 SHALL, on rst=1 at a clk edge, set state=IDLE, edge_count=0, bit_count=0, bit_done=0, frame_done=0, cfg_err=0 and all latched configuration to 0.
REQ-034 SHALL give rst priority over restart and counter_en, including during ACTIVE.
REQ-035 SHALL drive sample_strobe, sample_last and busy to 0 from the cycle after reset.

Verification
REQ-036 SHALL cover: P=8, data_len=11, par_en=0, stop2=0, counter_en held at 1 -> 10 bits and 80 enabled cycles, 10 bit_done pulses, frame_done in the cycle after the 80th enabled edge, strobes at edge_count 3, 4 and 5.
REQ-037 SHALL cover: P=16, data_len=00, par_en=1, stop2=1 -> L=9, frame_done after 144 enabled cycles, sample_last at edge_count 9.
REQ-038 SHALL cover: counter_en toggling 1/0 every cycle with P=8, 8N1 -> same counter sequence as REQ-036, with 160 cycles to frame_done.
REQ-039 SHALL cover: data_len changed 11->00 at bit_count=3 -> frame still ends at bit_count=9 (L=10).
REQ-040 SHALL cover: restart=1 together with counter_en=1 at bit_count=5 -> counters 0, busy=0, no frame_done; rst=1 mid-frame -> the REQ-033 values on the next cycle.
REQ-041 SHALL cover: prescale=3 latched -> cfg_err=1, busy=0, counters 0; then prescale=4 -> cfg_err=0 with strobes at edge_count 1, 2 and 3.

Source files
------------

// File: rtl/uart_rx_frame_counter.sv
// Edge and bit counter for a UART receiver: walks one frame of P clock edges per bit,
// decodes the three mid-bit sample points and pulses at each bit and frame boundary.
module uart_rx_frame_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  counter_en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            data_len,
  input  logic                  par_en,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sample_strobe,
  output logic                  sample_last,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  cfg_err
);

  localparam int CW = PRESCALE_W + 1;
  localparam int BW = BIT_CNT_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_count_q, edge_count_d;
  logic [BIT_CNT_W-1:0]    bit_count_q, bit_count_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic [1:0]              data_len_q, data_len_d;
  logic                    par_en_q, par_en_d;
  logic                    stop2_q, stop2_d;
  logic                    bit_done_q, bit_done_d;
  logic                    frame_done_q, frame_done_d;
  logic                    cfg_err_q, cfg_err_d;

  // Widened copies so that P-1 and h-1 can never wrap around.
  logic [CW-1:0] p_ext, p_last, half, edge_ext;
  logic [BW-1:0] bit_ext, bit_last;
  logic          edge_at_end, bit_at_end, prescale_ok;

  always_comb begin
    p_ext       = {1'b0, prescale_q};
    p_last      = p_ext - CW'(1);
    half        = p_ext >> 1;
    edge_ext    = {1'b0, edge_count_q};
    bit_ext     = {1'b0, bit_count_q};
    // Index of the last bit: start + data + parity + stops, minus one.
    bit_last    = BW'(data_len_q) + BW'(6) + BW'(par_en_q) + BW'(stop2_q);
    edge_at_end = (edge_ext == p_last);
    bit_at_end  = (bit_ext == bit_last);
    prescale_ok = ({1'b0, prescale} >= CW'(4));
  end

  always_comb begin
    state_d      = state_q;
    edge_count_d = edge_count_q;
    bit_count_d  = bit_count_q;
    prescale_d   = prescale_q;
    data_len_d   = data_len_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    cfg_err_d    = cfg_err_q;
    bit_done_d   = 1'b0;
    frame_done_d = 1'b0;

    if (restart) begin
      state_d      = IDLE;
      edge_count_d = '0;
      bit_count_d  = '0;
      cfg_err_d    = 1'b0;
    end else if (counter_en) begin
      unique case (state_q)
        IDLE: begin
          prescale_d   = prescale;
          data_len_d   = data_len;
          par_en_d     = par_en;
          stop2_d      = stop2;
          edge_count_d = '0;
          bit_count_d  = '0;
          if (prescale_ok) begin
            // The latch cycle is itself edge 0 of the start bit.
            cfg_err_d    = 1'b0;
            state_d      = ACTIVE;
            edge_count_d = PRESCALE_W'(1);
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (!edge_at_end) begin
            edge_count_d = edge_count_q + PRESCALE_W'(1);
          end else begin
            edge_count_d = '0;
            bit_done_d   = 1'b1;
            if (bit_at_end) begin
              bit_count_d  = '0;
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              bit_count_d = bit_count_q + BIT_CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      edge_count_q <= '0;
      bit_count_q  <= '0;
      prescale_q   <= '0;
      data_len_q   <= '0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      bit_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_count_q <= edge_count_d;
      bit_count_q  <= bit_count_d;
      prescale_q   <= prescale_d;
      data_len_q   <= data_len_d;
      par_en_q     <= par_en_d;
      stop2_q      <= stop2_d;
      bit_done_q   <= bit_done_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign busy          = (state_q == ACTIVE);
  assign edge_count    = edge_count_q;
  assign bit_count     = bit_count_q;
  assign bit_done      = bit_done_q;
  assign frame_done    = frame_done_q;
  assign cfg_err       = cfg_err_q;
  assign sample_strobe = busy && ((edge_ext == half - CW'(1)) ||
                                  (edge_ext == half) ||
                                  (edge_ext == half + CW'(1)));
  assign sample_last   = busy && (edge_ext == half + CW'(1));

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Bench for uart_rx_frame_counter: directed frame scenarios plus random traffic, scored
// against a model that counts enabled edges per frame with plain integer arithmetic.
module tb_uart_rx_frame_counter;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int QW = BW + 1;

  logic          clk = 1'b0;
  logic          rst, counter_en, restart;
  logic [PW-1:0] prescale;
  logic [1:0]    data_len;
  logic          par_en, stop2;
  logic [PW-1:0] edge_count;
  logic [BW-1:0] bit_count;
  logic          sample_strobe, sample_last, bit_done, frame_done, busy, cfg_err;

  always #5 clk = ~clk;

  uart_rx_frame_counter #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk(clk), .rst(rst), .counter_en(counter_en), .restart(restart),
    .prescale(prescale), .data_len(data_len), .par_en(par_en), .stop2(stop2),
    .edge_count(edge_count), .bit_count(bit_count), .sample_strobe(sample_strobe),
    .sample_last(sample_last), .bit_done(bit_done), .frame_done(frame_done),
    .busy(busy), .cfg_err(cfg_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q[$];   // {frame_done, bit_count} for each expected bit_done pulse
  bit mon_en = 1'b0;

  // Reference model: m_n = enabled edges consumed in the current frame.
  bit m_active  = 1'b0;
  bit m_cfg_err = 1'b0;
  int m_n   = 0;
  int m_p   = 0;
  int m_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int dl, input int pe, input int s2);
    return 1 + (dl + 5) + pe + 1 + s2;
  endfunction

  task automatic model_update(input bit en, input bit rs, input bit r);
    if (r) begin
      m_active = 0; m_n = 0; m_p = 0; m_len = 0; m_cfg_err = 0;
    end else if (rs) begin
      m_active = 0; m_n = 0; m_cfg_err = 0;
    end else if (en) begin
      if (!m_active) begin
        m_p   = int'(prescale);
        m_len = frame_len(int'(data_len), int'(par_en), int'(stop2));
        m_n   = 0;
        if (m_p < 4) m_cfg_err = 1;
        else begin
          m_cfg_err = 0; m_active = 1; m_n = 1;
        end
      end else begin
        m_n++;
        if (m_n % m_p == 0) begin
          if (m_n == m_len * m_p) begin
            exp_q.push_back({1'b1, BW'(0)});
            m_active = 0; m_n = 0;
          end else begin
            exp_q.push_back({1'b0, BW'(m_n / m_p)});
          end
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic rs, input logic r);
    counter_en = en; restart = rs; rst = r;
    @(posedge clk);
    model_update(en, rs, r);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    int e_edge, e_bit, h;
    logic [QW-1:0] e;
    if (mon_en) begin
      e_edge = m_active ? m_n % m_p : 0;
      e_bit  = m_active ? m_n / m_p : 0;
      h      = m_p / 2;
      check("busy", int'(busy), int'(m_active));
      check("edge_count", int'(edge_count), e_edge);
      check("bit_count", int'(bit_count), e_bit);
      check("cfg_err", int'(cfg_err), int'(m_cfg_err));
      check("sample_strobe", int'(sample_strobe), int'(m_active && e_edge >= h - 1 && e_edge <= h + 1));
      check("sample_last", int'(sample_last), int'(m_active && e_edge == h + 1));
      check("bit_done", int'(bit_done), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bit_done) begin
          check("frame_done", int'(frame_done), int'(e[QW-1]));
          check("bit_done_index", int'(bit_count), int'(e[BW-1:0]));
        end
      end else begin
        check("frame_done_quiet", int'(frame_done), 0);
      end
    end
  end

  // Runs from IDLE until frame_done shows, counting clock cycles.
  task automatic run_frame(input int exp_cycles, input bit toggle, input int change_bit,
                           input string name);
    int cycles;
    bit seen;
    cycles = 0; seen = 0;
    while (!seen && cycles < 2000) begin
      if (change_bit >= 0 && m_active && (m_n / m_p) == change_bit) data_len = 2'b00;
      step(toggle ? cycles[0] : 1'b1, 1'b0, 1'b0);
      cycles++;
      seen = frame_done;
    end
    check(name, cycles, exp_cycles);
  endtask

  task automatic run_to_bit(input int target);
    int guard;
    guard = 0;
    while (!(m_active && (m_n / m_p) == target) && guard < 500) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("reach_bit", m_active ? m_n / m_p : -1, target);
  endtask

  initial begin
    rst = 1'b1; counter_en = 1'b0; restart = 1'b0;
    prescale = 6'd8; data_len = 2'b11; par_en = 1'b0; stop2 = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // P=8, 8N1, enable held high: 80 enabled cycles.
    run_frame(80, 1'b0, -1, "latency_p8_8n1");
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // P=16, 5 data, parity, two stops: L=9.
    prescale = 6'd16; data_len = 2'b00; par_en = 1'b1; stop2 = 1'b1;
    run_frame(144, 1'b0, -1, "latency_p16_5e2");
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Enable toggling every cycle doubles the elapsed time.
    prescale = 6'd8; data_len = 2'b11; par_en = 1'b0; stop2 = 1'b0;
    run_frame(160, 1'b1, -1, "latency_toggle_en");
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Mid-frame config change is ignored.
    data_len = 2'b11;
    run_frame(80, 1'b0, 3, "latency_cfg_change");
    data_len = 2'b11;
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Restart with enable at bit 5, then reset mid-frame.
    run_to_bit(5);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    run_to_bit(2);
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Invalid prescale, then the smallest valid one.
    prescale = 6'd3;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    prescale = 6'd4;
    run_frame(40, 1'b0, -1, "latency_p4_8n1");
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Random traffic with occasional config changes, restarts and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        prescale = PW'($urandom_range(2, 12));
        data_len = 2'($urandom_range(0, 3));
        par_en   = 1'($urandom_range(0, 1));
        stop2    = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 399) == 0));
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
